// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port 64-bit memory between fetch (read-only) and load/store.
// Build option ARB_RR_EN: round-robin tie break instead of fixed load/store priority.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [63:0]   if_rdata,
  input  logic          dm_req_valid,
  output logic          dm_req_ready,
  input  logic [AW-1:0] dm_addr,
  input  logic          dm_we,
  input  logic [7:0]    dm_wstrb,
  input  logic [63:0]   dm_wdata,
  output logic          dm_rsp_valid,
  output logic [63:0]   dm_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-4:0] mem_addr,
  output logic [7:0]    mem_wstrb,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_dm;
  logic          gnt_dm;
  logic          gnt_we;
  logic          pick_dm;
  logic          accept;
  logic          unused;

  // Handshake: a request is taken on any rising edge where valid and ready are both
  // high; the requester must keep valid and payload stable until that edge.
  always_comb begin
    pick_dm = dm_req_valid;
`ifdef ARB_RR_EN
    if (dm_req_valid && if_req_valid) pick_dm = !last_dm;
`endif
  end

  // Gating with rst keeps every output quiet while reset is held.
  assign accept       = rst && (state == IDLE) && (if_req_valid || dm_req_valid);
  assign dm_req_ready = accept && pick_dm;
  assign if_req_ready = accept && !pick_dm;

  assign mem_cs    = accept;
  assign mem_we    = dm_req_ready && dm_we;
  assign mem_addr  = dm_req_ready ? dm_addr[AW-1:3] :
                     (if_req_ready ? if_addr[AW-1:3] : '0);
  assign mem_wstrb = dm_req_ready ? dm_wstrb : '0;
  assign mem_wdata = dm_req_ready ? dm_wdata : '0;

  assign dbg_state = state;
  assign unused    = ^{if_addr[2:0], dm_addr[2:0], last_dm};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_dm      <= 1'b0;
      gnt_dm       <= 1'b0;
      gnt_we       <= 1'b0;
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_dm  <= pick_dm;
            gnt_we  <= pick_dm && dm_we;
            last_dm <= pick_dm;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Final wait cycle is the one where mem_rdata is valid.
          if (cnt == CW'(MEM_LAT - 1)) begin
            if (gnt_dm) begin
              dm_rdata     <= gnt_we ? '0 : mem_rdata;
              dm_rsp_valid <= 1'b1;
            end else begin
              if_rdata     <= mem_rdata;
              if_rsp_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
